// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared opcodes, state encoding and width for the ALU stage.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 5;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_seq32_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq32_if
//  Description : Request/response handshake bundle for the ALU stage.
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_seq32_if;
    import alu_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [3:0]        op;
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] in2;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              carry;
    logic              ovf;
    logic              err;

    modport master (
        output in_valid, op, in1, in2, out_ready,
        input  in_ready, out_valid, result, zero, carry, ovf, err
    );

    modport slave (
        input  in_valid, op, in1, in2, out_ready,
        output in_ready, out_valid, result, zero, carry, ovf, err
    );

endinterface
`default_nettype wire

// File: rtl/alu_comb32.sv
`default_nettype none
// ============================================================================
//  Module      : alu_comb32
//  Description : Single-cycle logic, arithmetic, compare and shift datapath.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_comb32
    import alu_pkg::*;
(
    input  wire logic [3:0]        i_op,
    input  wire logic [DATA_W-1:0] i_in1,
    input  wire logic [DATA_W-1:0] i_in2,
    output logic      [DATA_W-1:0] o_result,
    output logic                   o_carry,
    output logic                   o_ovf,
    output logic                   o_err
);

    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_diff;
    logic [4:0]      w_shamt;

    assign w_sum   = {1'b0, i_in1} + {1'b0, i_in2};
    // Subtraction as in1 + ~in2 + 1 so bit 32 reads as "no borrow".
    assign w_diff  = {1'b0, i_in1} + {1'b0, ~i_in2} + {{DATA_W{1'b0}}, 1'b1};
    assign w_shamt = i_in2[4:0];

    always_comb begin
        o_result = '0;
        o_carry  = 1'b0;
        o_ovf    = 1'b0;
        o_err    = 1'b0;
        case (i_op)
            OP_AND:  o_result = i_in1 & i_in2;
            OP_OR:   o_result = i_in1 | i_in2;
            OP_XOR:  o_result = i_in1 ^ i_in2;
            OP_NOR:  o_result = ~(i_in1 | i_in2);
            OP_ADD: begin
                o_result = w_sum[DATA_W-1:0];
                o_carry  = w_sum[DATA_W];
                o_ovf    = (i_in1[31] == i_in2[31]) && (w_sum[31] != i_in1[31]);
            end
            OP_SUB: begin
                o_result = w_diff[DATA_W-1:0];
                o_carry  = w_diff[DATA_W];
                o_ovf    = (i_in1[31] != i_in2[31]) && (w_diff[31] != i_in1[31]);
            end
            OP_SLT: begin
                o_result = {{(DATA_W-1){1'b0}}, ($signed(i_in1) < $signed(i_in2))};
                o_carry  = w_diff[DATA_W];
            end
            OP_SLTU: begin
                o_result = {{(DATA_W-1){1'b0}}, (i_in1 < i_in2)};
                o_carry  = w_diff[DATA_W];
            end
            OP_SLL:  o_result = i_in1 << w_shamt;
            OP_SRL:  o_result = i_in1 >> w_shamt;
            OP_SRA:  o_result = $unsigned($signed(i_in1) >>> w_shamt);
            OP_MUL:  o_result = '0;
            default: o_err    = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq32.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq32
//  Description : Handshaked 32-bit ALU stage with a 32-step shift-add multiplier.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_seq32
    import alu_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   rst,
    alu_seq32_if.slave  bus
);

    state_t            state_q,  state_d;
    logic [DATA_W-1:0] mcand_q,  mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] acc_q,    acc_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q,   zero_d;
    logic              carry_q,  carry_d;
    logic              ovf_q,    ovf_d;
    logic              err_q,    err_d;

    logic              w_in_ready;
    logic              w_accept;
    logic [DATA_W-1:0] w_alu_result;
    logic              w_alu_carry;
    logic              w_alu_ovf;
    logic              w_alu_err;

    alu_comb32 u_alu_comb32 (
        .i_op     (bus.op),
        .i_in1    (bus.in1),
        .i_in2    (bus.in2),
        .o_result (w_alu_result),
        .o_carry  (w_alu_carry),
        .o_ovf    (w_alu_ovf),
        .o_err    (w_alu_err)
    );

    assign w_in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        err_d    = err_q;

        case (state_q)
            S_MUL: begin
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    result_d = acc_d;
                    zero_d   = (acc_d == '0);
                    carry_d  = 1'b0;
                    ovf_d    = 1'b0;
                    err_d    = 1'b0;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready && !bus.in_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase

        // Acceptance is only possible from IDLE or a draining DONE, so it
        // never competes with the MUL iteration above.
        if (w_accept) begin
            if (bus.op == OP_MUL) begin
                mcand_d  = bus.in1;
                mplier_d = bus.in2;
                acc_d    = '0;
                cnt_d    = '0;
                state_d  = S_MUL;
            end else begin
                result_d = w_alu_result;
                zero_d   = (w_alu_result == '0);
                carry_d  = w_alu_carry;
                ovf_d    = w_alu_ovf;
                err_d    = w_alu_err;
                state_d  = S_DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = carry_q;
    assign bus.ovf       = ovf_q;
    assign bus.err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq32
//  Description : Directed self-checking bench for the alu_seq32 stage.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_seq32;
    import alu_pkg::*;

    logic clk;
    logic rst;
    int   n_asserts;
    int   n_fail;

    alu_seq32_if bus ();

    alu_seq32 u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one request for exactly one edge; caller sits #1 after an edge.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.in1      = a;
        bus.in2      = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int exp_cycles);
        int cyc;
        logic rdy_seen;
        cyc      = 0;
        rdy_seen = 1'b0;
        while (!bus.out_valid && cyc < 40) begin
            if (bus.in_ready) rdy_seen = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(exp_cycles));
        chk({tag, "_in_ready_low"}, {31'b0, rdy_seen}, 32'd0);
    endtask

    initial begin
        n_asserts     = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = OP_AND;
        bus.in1       = '0;
        bus.in2       = '0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_result",    bus.result,             32'd0);
        chk("rst_flags",     {28'b0, bus.zero, bus.carry, bus.ovf, bus.err}, 32'd0);
        chk("rst_in_ready",  {31'b0, bus.in_ready},  32'd1);

        send(OP_AND, 32'hF0F0_1234, 32'hFFFF_00FF);
        chk("and_valid",  {31'b0, bus.out_valid}, 32'd1);
        chk("and_result", bus.result,             32'hF0F0_0034);
        chk("and_zero",   {31'b0, bus.zero},      32'd0);

        send(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        chk("add_result", bus.result,        32'h8000_0000);
        chk("add_ovf",    {31'b0, bus.ovf},   32'd1);
        chk("add_carry",  {31'b0, bus.carry}, 32'd0);

        send(OP_SUB, 32'd5, 32'd5);
        chk("sub_result", bus.result,        32'd0);
        chk("sub_zero",   {31'b0, bus.zero},  32'd1);
        chk("sub_carry",  {31'b0, bus.carry}, 32'd1);
        chk("sub_ovf",    {31'b0, bus.ovf},   32'd0);

        send(OP_SLT, 32'hFFFF_FFFF, 32'd1);
        chk("slt_result", bus.result,        32'd1);
        chk("slt_carry",  {31'b0, bus.carry}, 32'd1);

        send(OP_SLTU, 32'hFFFF_FFFF, 32'd1);
        chk("sltu_result", bus.result,       32'd0);
        chk("sltu_zero",   {31'b0, bus.zero}, 32'd1);

        send(OP_SRA, 32'h8000_0000, 32'h0000_0024);
        chk("sra_result", bus.result, 32'hF800_0000);

        send(OP_SLL, 32'h1234_5678, 32'h0000_0020);
        chk("sll0_result", bus.result, 32'h1234_5678);

        send(OP_SRL, 32'h8000_0000, 32'd31);
        chk("srl_result", bus.result, 32'd1);

        send(OP_NOR, 32'h0000_0000, 32'h0000_0000);
        chk("nor_result", bus.result, 32'hFFFF_FFFF);

        send(OP_MUL, 32'h0001_0001, 32'h0000_FFFF);
        wait_out("mul1", 32);
        chk("mul1_result", bus.result, 32'hFFFF_FFFF);

        send(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_out("mul2", 32);
        chk("mul2_result", bus.result, 32'h0000_0001);
        chk("mul2_flags",  {28'b0, bus.zero, bus.carry, bus.ovf, bus.err}, 32'd0);

        // Consumer stalls for five cycles while the request lines churn.
        send(OP_OR, 32'h0F00_00F0, 32'h0000_0F0F);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.op       = OP_XOR;
            bus.in1      = $urandom;
            bus.in2      = $urandom;
            @(posedge clk);
            #1;
            chk("hold_result",   bus.result,             32'h0F00_0FFF);
            chk("hold_in_ready", {31'b0, bus.in_ready},  32'd0);
            chk("hold_valid",    {31'b0, bus.out_valid}, 32'd1);
        end
        bus.out_ready = 1'b1;
        bus.in1       = 32'hA5A5_A5A5;
        bus.in2       = 32'h0F0F_0F0F;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("xor_result", bus.result,             32'hAAAA_AAAA);
        chk("xor_valid",  {31'b0, bus.out_valid}, 32'd1);

        // Reset in the middle of a multiply.
        send(OP_MUL, 32'd3, 32'd5);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("midrst_result",    bus.result,             32'd0);
        chk("midrst_flags",     {28'b0, bus.zero, bus.carry, bus.ovf, bus.err}, 32'd0);
        chk("midrst_in_ready",  {31'b0, bus.in_ready},  32'd1);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("midrst_no_partial", {31'b0, bus.out_valid}, 32'd0);

        send(4'b1110, 32'hFFFF_FFFF, 32'd1);
        chk("ill_valid",  {31'b0, bus.out_valid}, 32'd1);
        chk("ill_result", bus.result,             32'd0);
        chk("ill_err",    {31'b0, bus.err},       32'd1);
        chk("ill_zero",   {31'b0, bus.zero},      32'd1);
        chk("ill_cv",     {30'b0, bus.carry, bus.ovf}, 32'd0);

        @(posedge clk);
        #1;
        chk("drain_idle", {30'b0, bus.out_valid, bus.in_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_seq32.md
# alu_seq32

Sequential 32-bit integer ALU stage that accepts an operation and two operands over a valid/ready handshake, computes the result, and presents it with status flags until the consumer takes it. It drives the bitwise, arithmetic and shift units from one latched operand pair. It also adds a 32-iteration shift-add multiplier for the low product word. It sits between operand fetch/decode and the write-back register.

## Interface
- No parameters; datapath width fixed at 32.
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  stage can accept a request this cycle.
- op  in  4  operation code (encodings in Operation).
- in1  in  32  operand A.
- in2  in  32  operand B; shift amount is in2[4:0].
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer takes the result this cycle.
- result  out  32  computed value.
- zero  out  1  result == 0.
- carry  out  1  ADD: carry-out; SUB/SLT/SLTU: bit 32 of in1 + ~in2 + 1 (1 = no borrow); otherwise 0.
- ovf  out  1  signed overflow for ADD/SUB; otherwise 0.
- err  out  1  illegal opcode; result forced to 0.

## Operation
- Opcodes:
  - 0000 AND, 0001 OR, 0010 XOR, 0011 NOR.
  - 0100 ADD, 0101 SUB.
  - 0110 SLT (signed, result 0/1), 0111 SLTU (unsigned).
  - 1000 SLL, 1001 SRL, 1010 SRA.
  - 1011 MUL (low 32 bits of the product; identical for signed and unsigned).
  - 1100–1111 illegal.
- FSM states:
  - IDLE: in_ready=1. On in_valid:
    - MUL → load mcand=in1, mplier=in2, acc=0, cnt=0, go to MUL.
    - Otherwise → register the single-cycle result and flags, go to DONE.
  - MUL: each cycle, if mplier[0], acc += mcand. Then mcand <<= 1, mplier >>= 1, cnt++. When cnt==31, the final iteration is written and the FSM goes to DONE. No early termination. carry, ovf and err are 0; zero is computed from the final acc.
  - DONE: out_valid=1; result and flags held stable.
    - out_ready=1 with in_valid=0 → IDLE.
    - out_ready=1 with in_valid=1 → the new request is accepted in the same cycle (in_ready=1), with the same transitions as from IDLE.
    - out_ready=0 → stay in DONE with in_ready=0.
- in_ready = (state==IDLE) | (state==DONE & out_ready). in_ready is 0 throughout MUL.
- Arithmetic is modulo 2^32. Shifts use in2[4:0] only; in2[31:5] is ignored. SRA replicates in1[31].
- Illegal op: result=0, zero=1, err=1, carry=0, ovf=0. Latency is the same as for a single-cycle op.
- Inputs are sampled only on the accept edge (in_valid & in_ready). Changes to the inputs at any other time have no effect.

## Timing
- Reset: state=IDLE; out_valid=0; result=0; zero, carry, ovf and err all 0; in_ready=1 in the first cycle after reset.
- Reset asserted in any state, including mid-MUL, aborts the operation and restores the reset values on the next edge. No partial result is presented.
- Single-cycle ops: accept at edge k → out_valid=1 after edge k.
- MUL: accept at edge k → iterations at edges k+1…k+32 → out_valid=1 after edge k+32.
- Back-to-back single-cycle ops with out_ready held high give one result per cycle.
- While out_valid=1 and out_ready=0, result and flags must not change.

## Structure
- Package alu_pkg holds:
  - the 4-bit opcode localparams;
  - the state encoding (IDLE, MUL, DONE);
  - the width constant 32.
- Sub-module alu_comb32: purely combinational. Inputs are op, in1 and in2; outputs are result, carry, ovf and err for all non-MUL ops. The top level holds the FSM, the multiplier registers, the 5-bit counter and the output registers.

## Test plan
- Reset then AND with in1=0xF0F0_1234, in2=0xFFFF_00FF → result=0xF0F0_0034, zero=0, out_valid one cycle after accept.
- ADD 0x7FFF_FFFF+1 → result=0x8000_0000, ovf=1, carry=0. SUB 5−5 → result=0, zero=1, carry=1. SLT 0xFFFF_FFFF vs 1 → 1; SLTU with the same operands → 0.
- SRA in1=0x8000_0000, in2=0x0000_0024 (amount 4) → 0xF800_0000. SLL with amount 0 → in1 unchanged.
- MUL 0x0001_0001 × 0x0000_FFFF → 0xFFFF_FFFF exactly 32 cycles after accept, with in_ready=0 throughout. MUL 0xFFFF_FFFF × 0xFFFF_FFFF → 0x0000_0001.
- Hold out_ready=0 for 5 cycles after an OR result while in1/in2 toggle → result stable, in_ready=0. Then out_ready=1 with in_valid=1 (XOR) → next result on the following cycle.
- Assert rst at cycle 10 of a MUL → all outputs return to reset values and in_ready=1 next cycle. Illegal op 1110 → result=0, err=1, zero=1.
